// File: rtl/iq_sequencer.sv
// iq_sequencer: parses a USB byte stream of A5-prefixed commands, buffers I/Q sample
// pairs in a FIFO and plays them out at a programmable rate. Define IQSEQ_STATUS_EN for status LEDs.
module iq_sequencer #(
  parameter int IQW         = 8,
  parameter int DEPTH       = 16,
  parameter int DIV_DEFAULT = 50000
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [IQW-1:0]         i,
  output logic [IQW-1:0]         q,
  output logic                   iq_update,
  output logic                   running,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             status
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL    = (AW+1)'(DEPTH);
  localparam logic [7:0]  SYNC        = 8'hA5;
  localparam logic [7:0]  CMD_SET_DIV = 8'h01;
  localparam logic [7:0]  CMD_LOAD    = 8'h02;
  localparam logic [7:0]  CMD_START   = 8'h03;
  localparam logic [7:0]  CMD_STOP    = 8'h04;
  localparam logic [7:0]  CMD_CLEAR   = 8'h05;

  typedef enum logic [1:0] {IDLE, CMD, ARG1, ARG2} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg1_q, arg1_d;
  logic            do_set_div, do_push, do_start, do_stop, do_clear, do_bad;

  logic [15:0]     div_q, cnt_q, div_val;
  logic            running_q, underrun_q, overflow_q, bad_cmd_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic [2*IQW-1:0] mem_q [DEPTH];
  logic [IQW-1:0]  i_q, q_q;
  logic            iq_update_q;

  logic            tick, fifo_empty, fifo_full, pop, push_ok;

  // Parser: decodes one byte per rx_valid cycle into single-cycle action strobes
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg1_d     = arg1_q;
    do_set_div = 1'b0;
    do_push    = 1'b0;
    do_start   = 1'b0;
    do_stop    = 1'b0;
    do_clear   = 1'b0;
    do_bad     = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: if (rx_data == SYNC) state_d = CMD;
        CMD: begin
          cmd_d   = rx_data;
          state_d = IDLE;
          case (rx_data)
            CMD_SET_DIV, CMD_LOAD: state_d = ARG1;
            CMD_START: do_start = 1'b1;
            CMD_STOP:  do_stop  = 1'b1;
            CMD_CLEAR: do_clear = 1'b1;
            default:   do_bad   = 1'b1;
          endcase
        end
        ARG1: begin
          arg1_d  = rx_data;
          state_d = ARG2;
        end
        ARG2: begin
          state_d = IDLE;
          if (cmd_q == CMD_SET_DIV) do_set_div = 1'b1;
          else                      do_push    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign div_val    = {arg1_q, rx_data};
  assign tick       = running_q && (cnt_q == div_q - 16'd1);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  // CLEAR wins over a coincident tick: no pop and no underrun that cycle
  assign pop        = tick && !fifo_empty && !do_clear;
  assign push_ok    = do_push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= IDLE;
      div_q       <= 16'(DIV_DEFAULT);
      cnt_q       <= '0;
      running_q   <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      bad_cmd_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      i_q         <= '0;
      q_q         <= '0;
      iq_update_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (do_set_div) div_q <= (div_val == 16'd0) ? 16'd1 : div_val;

      if (do_set_div || do_start) cnt_q <= '0;
      else if (running_q)         cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;

      if (do_start)     running_q <= 1'b1;
      else if (do_stop) running_q <= 1'b0;

      if (do_clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        underrun_q <= 1'b0;
        overflow_q <= 1'b0;
        bad_cmd_q  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push_ok, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
        underrun_q <= underrun_q | (tick && fifo_empty);
        overflow_q <= overflow_q | (do_push && fifo_full && !pop);
        bad_cmd_q  <= bad_cmd_q | do_bad;
      end

      if (pop) {i_q, q_q} <= mem_q[rd_ptr_q];
      iq_update_q <= pop;
    end
  end

  // Sample storage and parse scratch carry no reset; they are qualified by level/state
  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    arg1_q <= arg1_d;
    if (push_ok) mem_q[wr_ptr_q] <= {IQW'(arg1_q), IQW'(rx_data)};
  end

  assign i          = i_q;
  assign q          = q_q;
  assign iq_update  = iq_update_q;
  assign running    = running_q;
  assign fifo_level = level_q;

`ifdef IQSEQ_STATUS_EN
  logic [3:0] lvl_sat;
  always_comb begin
    if (32'(level_q) > 32'd15) lvl_sat = 4'hf;
    else                       lvl_sat = 4'(level_q);
  end
  assign status = ~{running_q, underrun_q, overflow_q, bad_cmd_q, lvl_sat};
`else
  assign status = 8'hff;
`endif

endmodule
